// File: rtl/layer_serializer_pkg.sv
// layer_serializer_pkg
// Shared definitions for the layer-to-layer vector serializer:
//   dataWidth         default bits per neuron output element
//   numNeuronLayer1   neurons in Layer_1 (elements per serialized vector)
//   numNeuronLayer2   neurons in Layer_2
//   idx_width()       element-index width helper (ceil log2, never below 1)
//   stream_state_t    serializer FSM states
package layer_serializer_pkg;

    localparam int dataWidth       = 16;
    localparam int numNeuronLayer1 = 50;
    localparam int numNeuronLayer2 = 10;

    // Smallest width that can index n elements, with a floor of 1 bit so a
    // single-element vector still has a legal index port.
    function automatic int idx_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } stream_state_t;

endpackage

// File: rtl/layer_vec_slot2.sv
// layer_vec_slot2
// Two-entry FIFO of whole vectors feeding the serializer.
// Ports:
//   s_axi_aclk, reset   clock, synchronous active-high reset
//   wr_valid, wr_data   one-cycle vector strobe and its payload
//   wr_ready            a slot is free (decided from occupancy at cycle start)
//   rd_release          current read slot has been fully streamed
//   clr_overflow        clears the sticky overflow flag
//   occ                 number of occupied slots (0..2)
//   rd_vec              contents of the slot being streamed
//   nxt_vec             contents of the other slot (next vector in line)
//   overflow            sticky: a vector was dropped because both slots were full
module layer_vec_slot2
    import layer_serializer_pkg::*;
#(
    parameter int VEC_WIDTH = dataWidth * numNeuronLayer1
) (
    input  logic                 s_axi_aclk,
    input  logic                 reset,
    input  logic                 wr_valid,
    input  logic [VEC_WIDTH-1:0] wr_data,
    output logic                 wr_ready,
    input  logic                 rd_release,
    input  logic                 clr_overflow,
    output logic [1:0]           occ,
    output logic [VEC_WIDTH-1:0] rd_vec,
    output logic [VEC_WIDTH-1:0] nxt_vec,
    output logic                 overflow
);

    logic [VEC_WIDTH-1:0] slot_mem [2];
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic                 wr_accept;

    // Readiness looks only at occupancy at the start of the cycle, so a slot
    // freed by a last beat in the same cycle is not reused until the next one.
    assign wr_ready  = !reset && (occ < 2'd2);
    assign wr_accept = wr_valid && wr_ready;

    assign rd_vec  = slot_mem[rd_ptr];
    assign nxt_vec = slot_mem[~rd_ptr];

    // Payload storage carries no reset; occupancy alone says what is valid.
    always_ff @(posedge s_axi_aclk) begin
        if (wr_accept) begin
            slot_mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (reset) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            occ      <= 2'd0;
            overflow <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= ~wr_ptr;
            end
            if (rd_release) begin
                rd_ptr <= ~rd_ptr;
            end
            // Simultaneous accept and release leave occupancy unchanged.
            unique case ({wr_accept, rd_release})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
            // A fresh overrun takes priority over a clear in the same cycle.
            if (wr_valid && !wr_ready) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/layer_serializer.sv
// layer_serializer
// Captures a full layer output vector on a one-cycle strobe and replays it
// element by element with valid/ready handshaking. Two vectors can be held,
// so the next one can arrive while the current one is still streaming.
// Ports:
//   s_axi_aclk, reset   clock, synchronous active-high reset
//   in_valid, in_data   vector strobe; element k at in_data[k*DATA_WIDTH +: DATA_WIDTH]
//   in_ready            a vector slot is free
//   out_data/out_valid  current element and its valid flag
//   out_ready           downstream accepts the beat
//   out_last            current beat is element NUM_NEURONS-1
//   out_index           index of the current element
//   overflow            sticky drop flag, cleared by clr_overflow
//   busy                a slot is occupied or a beat is pending
module layer_serializer
    import layer_serializer_pkg::*;
#(
    parameter int DATA_WIDTH  = dataWidth,
    parameter int NUM_NEURONS = numNeuronLayer1,
    parameter int IDX_WIDTH   = idx_width(numNeuronLayer1)
) (
    input  logic                              s_axi_aclk,
    input  logic                              reset,
    input  logic                              in_valid,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0] in_data,
    output logic                              in_ready,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              out_last,
    output logic [IDX_WIDTH-1:0]              out_index,
    output logic                              overflow,
    input  logic                              clr_overflow,
    output logic                              busy
);

    localparam int                   VEC_WIDTH     = NUM_NEURONS * DATA_WIDTH;
    localparam logic [IDX_WIDTH-1:0] LAST_INDEX    = IDX_WIDTH'(NUM_NEURONS - 1);
    localparam logic                 FIRST_IS_LAST = (NUM_NEURONS == 1);

    stream_state_t         state;
    logic [1:0]            occ;
    logic [VEC_WIDTH-1:0]  rd_vec;
    logic [VEC_WIDTH-1:0]  nxt_vec;
    logic                  beat_release;
    logic [IDX_WIDTH-1:0]  next_index;
    logic [DATA_WIDTH-1:0] next_elem;
    logic [DATA_WIDTH-1:0] rd_elem0;
    logic [DATA_WIDTH-1:0] nxt_elem0;

    // The read slot is freed exactly when its last element is handed over.
    assign beat_release = out_valid && out_ready && out_last;

    layer_vec_slot2 #(
        .VEC_WIDTH (VEC_WIDTH)
    ) u_slots (
        .s_axi_aclk   (s_axi_aclk),
        .reset        (reset),
        .wr_valid     (in_valid),
        .wr_data      (in_data),
        .wr_ready     (in_ready),
        .rd_release   (beat_release),
        .clr_overflow (clr_overflow),
        .occ          (occ),
        .rd_vec       (rd_vec),
        .nxt_vec      (nxt_vec),
        .overflow     (overflow)
    );

    // Elements are picked by index straight out of the stored slot, so the
    // slot contents never change while it is being streamed.
    always_comb begin
        next_index = out_index + IDX_WIDTH'(1);
        next_elem  = rd_vec[int'(next_index)*DATA_WIDTH +: DATA_WIDTH];
        rd_elem0   = rd_vec[DATA_WIDTH-1:0];
        nxt_elem0  = nxt_vec[DATA_WIDTH-1:0];
    end

    // Stream FSM. All beat outputs are registered; during a stall nothing is
    // written, which keeps out_data/out_index/out_last stable. When the last
    // beat goes out with the other slot already full, its element 0 is loaded
    // directly so consecutive vectors run without a bubble.
    always_ff @(posedge s_axi_aclk) begin
        if (reset) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_index <= '0;
            out_data  <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (occ != 2'd0) begin
                        state     <= ST_STREAM;
                        out_valid <= 1'b1;
                        out_index <= '0;
                        out_data  <= rd_elem0;
                        out_last  <= FIRST_IS_LAST;
                    end
                end
                ST_STREAM: begin
                    if (out_valid && out_ready) begin
                        if (out_last) begin
                            if (occ == 2'd2) begin
                                out_index <= '0;
                                out_data  <= nxt_elem0;
                                out_last  <= FIRST_IS_LAST;
                            end else begin
                                state     <= ST_IDLE;
                                out_valid <= 1'b0;
                                out_last  <= 1'b0;
                                out_index <= '0;
                            end
                        end else begin
                            out_index <= next_index;
                            out_data  <= next_elem;
                            out_last  <= (next_index == LAST_INDEX);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (occ != 2'd0) || out_valid;

endmodule

// File: tb/tb_layer_serializer.sv
// tb_layer_serializer
// Directed bench for layer_serializer: a 4-element instance (a_*) covers the
// streaming, backpressure, back-to-back, overrun and reset cases; a 1-element
// instance (b_*) covers the degenerate single-element vector.
module tb_layer_serializer;

    localparam logic [63:0] VEC_A = 64'h0004_0003_0002_0001;
    localparam logic [63:0] VEC_B = 64'h0014_0013_0012_0011;
    localparam logic [63:0] VEC_C = 64'h0024_0023_0022_0021;

    logic        s_axi_aclk;
    logic        reset;

    logic        a_in_valid;
    logic [63:0] a_in_data;
    logic        a_in_ready;
    logic [15:0] a_out_data;
    logic        a_out_valid;
    logic        a_out_ready;
    logic        a_out_last;
    logic [1:0]  a_out_index;
    logic        a_overflow;
    logic        a_clr_overflow;
    logic        a_busy;

    logic        b_in_valid;
    logic [15:0] b_in_data;
    logic        b_in_ready;
    logic [15:0] b_out_data;
    logic        b_out_valid;
    logic        b_out_ready;
    logic        b_out_last;
    logic [0:0]  b_out_index;
    logic        b_overflow;
    logic        b_clr_overflow;
    logic        b_busy;

    int checks = 0;
    int errors = 0;

    layer_serializer #(
        .DATA_WIDTH  (16),
        .NUM_NEURONS (4),
        .IDX_WIDTH   (2)
    ) dut_a (
        .s_axi_aclk   (s_axi_aclk),
        .reset        (reset),
        .in_valid     (a_in_valid),
        .in_data      (a_in_data),
        .in_ready     (a_in_ready),
        .out_data     (a_out_data),
        .out_valid    (a_out_valid),
        .out_ready    (a_out_ready),
        .out_last     (a_out_last),
        .out_index    (a_out_index),
        .overflow     (a_overflow),
        .clr_overflow (a_clr_overflow),
        .busy         (a_busy)
    );

    layer_serializer #(
        .DATA_WIDTH  (16),
        .NUM_NEURONS (1),
        .IDX_WIDTH   (1)
    ) dut_b (
        .s_axi_aclk   (s_axi_aclk),
        .reset        (reset),
        .in_valid     (b_in_valid),
        .in_data      (b_in_data),
        .in_ready     (b_in_ready),
        .out_data     (b_out_data),
        .out_valid    (b_out_valid),
        .out_ready    (b_out_ready),
        .out_last     (b_out_last),
        .out_index    (b_out_index),
        .overflow     (b_overflow),
        .clr_overflow (b_clr_overflow),
        .busy         (b_busy)
    );

    initial s_axi_aclk = 1'b0;
    always #5 s_axi_aclk = ~s_axi_aclk;

    function automatic logic [15:0] elemOf(input logic [63:0] vec, input int k);
        return vec[k*16 +: 16];
    endfunction

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge s_axi_aclk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs on the 4-element instance.
    task automatic applyStimulus(input logic valid, input logic [63:0] data, input logic ready, input logic clr);
        a_in_valid     = valid;
        a_in_data      = data;
        a_out_ready    = ready;
        a_clr_overflow = clr;
        tick();
    endtask

    // Check that the 4-element instance presents element idx of vec.
    task automatic checkBeat(input string tag, input logic [63:0] vec, input int idx);
        checkOutput({tag, "_valid"}, 32'(a_out_valid), 32'd1);
        checkOutput({tag, "_data"},  32'(a_out_data),  32'(elemOf(vec, idx)));
        checkOutput({tag, "_index"}, 32'(a_out_index), 32'(idx));
        checkOutput({tag, "_last"},  32'(a_out_last),  32'(idx == 3));
    endtask

    initial begin
        int          n;
        logic        stalled;
        logic [15:0] held_data;
        logic [1:0]  held_index;
        logic        held_last;

        reset          = 1'b1;
        a_in_valid     = 1'b0;
        a_in_data      = '0;
        a_out_ready    = 1'b0;
        a_clr_overflow = 1'b0;
        b_in_valid     = 1'b0;
        b_in_data      = '0;
        b_out_ready    = 1'b0;
        b_clr_overflow = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        checkOutput("rst_out_valid", 32'(a_out_valid), 32'd0);
        checkOutput("rst_out_last",  32'(a_out_last),  32'd0);
        checkOutput("rst_out_index", 32'(a_out_index), 32'd0);
        checkOutput("rst_out_data",  32'(a_out_data),  32'd0);
        checkOutput("rst_overflow",  32'(a_overflow),  32'd0);
        checkOutput("rst_busy",      32'(a_busy),      32'd0);
        checkOutput("rst_in_ready",  32'(a_in_ready),  32'd0);
        checkOutput("rst_b_in_ready", 32'(b_in_ready), 32'd0);
        reset = 1'b0;
        tick();
        checkOutput("post_rst_in_ready",   32'(a_in_ready),  32'd1);
        checkOutput("post_rst_b_in_ready", 32'(b_in_ready),  32'd1);
        checkOutput("post_rst_out_valid",  32'(a_out_valid), 32'd0);

        // ---------------- basic stream ----------------
        applyStimulus(1'b1, VEC_A, 1'b1, 1'b0);
        a_in_valid = 1'b0;
        checkOutput("basic_latency_valid", 32'(a_out_valid), 32'd0);
        checkOutput("basic_busy_after_accept", 32'(a_busy), 32'd1);
        tick();
        for (int k = 0; k < 4; k++) begin
            checkBeat($sformatf("basic_beat%0d", k), VEC_A, k);
            tick();
        end
        checkOutput("basic_end_valid", 32'(a_out_valid), 32'd0);
        checkOutput("basic_end_busy",  32'(a_busy),      32'd0);

        // ---------------- backpressure ----------------
        applyStimulus(1'b1, VEC_A, 1'b0, 1'b0);
        a_in_valid = 1'b0;
        n = 0;
        for (int c = 0; c < 30; c++) begin
            a_out_ready = (c % 3 == 0);
            stalled     = 1'b0;
            held_data   = a_out_data;
            held_index  = a_out_index;
            held_last   = a_out_last;
            if (a_out_valid) begin
                if (a_out_ready) begin
                    if (n < 4) begin
                        checkOutput($sformatf("bp_beat%0d_data", n),  32'(a_out_data),  32'(elemOf(VEC_A, n)));
                        checkOutput($sformatf("bp_beat%0d_index", n), 32'(a_out_index), 32'(n));
                        checkOutput($sformatf("bp_beat%0d_last", n),  32'(a_out_last),  32'(n == 3));
                    end else begin
                        checkOutput("bp_extra_beat", 32'(a_out_valid), 32'd0);
                    end
                    n++;
                end else begin
                    stalled = 1'b1;
                end
            end
            tick();
            if (stalled) begin
                checkOutput("bp_stall_data",  32'(a_out_data),  32'(held_data));
                checkOutput("bp_stall_index", 32'(a_out_index), 32'(held_index));
                checkOutput("bp_stall_last",  32'(a_out_last),  32'(held_last));
            end
        end
        checkOutput("bp_transfer_count", 32'(n), 32'd4);
        checkOutput("bp_end_busy", 32'(a_busy), 32'd0);

        // ---------------- back-to-back ----------------
        checkOutput("b2b_in_ready_a", 32'(a_in_ready), 32'd1);
        applyStimulus(1'b1, VEC_A, 1'b1, 1'b0);
        a_in_valid = 1'b0;
        tick();
        checkBeat("b2b_beat0", VEC_A, 0);
        checkOutput("b2b_in_ready_b", 32'(a_in_ready), 32'd1);
        a_in_valid = 1'b1;
        a_in_data  = VEC_B;
        tick();
        a_in_valid = 1'b0;
        for (int k = 1; k < 8; k++) begin
            checkBeat($sformatf("b2b_beat%0d", k), (k < 4) ? VEC_A : VEC_B, k % 4);
            tick();
        end
        checkOutput("b2b_end_valid",    32'(a_out_valid), 32'd0);
        checkOutput("b2b_end_busy",     32'(a_busy),      32'd0);
        checkOutput("b2b_no_overflow",  32'(a_overflow),  32'd0);

        // ---------------- overrun ----------------
        applyStimulus(1'b1, VEC_A, 1'b0, 1'b0);
        checkOutput("ovr_in_ready_occ1", 32'(a_in_ready), 32'd1);
        applyStimulus(1'b1, VEC_B, 1'b0, 1'b0);
        checkOutput("ovr_in_ready_occ2", 32'(a_in_ready), 32'd0);
        checkOutput("ovr_flag_before",   32'(a_overflow), 32'd0);
        applyStimulus(1'b1, VEC_C, 1'b0, 1'b0);
        checkOutput("ovr_flag_set",      32'(a_overflow), 32'd1);
        checkOutput("ovr_held_data",     32'(a_out_data), 32'h0001);
        applyStimulus(1'b1, VEC_C, 1'b0, 1'b1);
        checkOutput("ovr_set_wins",      32'(a_overflow), 32'd1);
        applyStimulus(1'b0, VEC_C, 1'b0, 1'b1);
        checkOutput("ovr_cleared",       32'(a_overflow), 32'd0);
        a_clr_overflow = 1'b0;
        a_out_ready    = 1'b1;
        for (int k = 0; k < 8; k++) begin
            checkBeat($sformatf("ovr_beat%0d", k), (k < 4) ? VEC_A : VEC_B, k % 4);
            tick();
        end
        checkOutput("ovr_no_c_valid", 32'(a_out_valid), 32'd0);
        checkOutput("ovr_end_busy",   32'(a_busy),      32'd0);

        // ---------------- reset mid-stream ----------------
        applyStimulus(1'b1, VEC_A, 1'b1, 1'b0);
        a_in_valid = 1'b0;
        tick();
        checkBeat("mrst_beat0", VEC_A, 0);
        a_in_valid = 1'b1;
        a_in_data  = VEC_B;
        tick();
        a_in_valid = 1'b0;
        checkBeat("mrst_beat1", VEC_A, 1);
        tick();
        checkBeat("mrst_beat2", VEC_A, 2);
        reset = 1'b1;
        tick();
        checkOutput("mrst_out_valid", 32'(a_out_valid), 32'd0);
        checkOutput("mrst_in_ready",  32'(a_in_ready),  32'd0);
        checkOutput("mrst_busy",      32'(a_busy),      32'd0);
        checkOutput("mrst_index",     32'(a_out_index), 32'd0);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput("mrst_no_residual_valid", 32'(a_out_valid), 32'd0);
            checkOutput("mrst_no_residual_busy",  32'(a_busy),      32'd0);
        end
        checkOutput("mrst_in_ready_after", 32'(a_in_ready), 32'd1);
        applyStimulus(1'b1, VEC_C, 1'b1, 1'b0);
        a_in_valid = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            checkBeat($sformatf("mrst_new_beat%0d", k), VEC_C, k);
            tick();
        end
        checkOutput("mrst_new_end_valid", 32'(a_out_valid), 32'd0);

        // ---------------- single-element vectors ----------------
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        b_in_data   = 16'hBEEF;
        tick();
        b_in_valid = 1'b0;
        checkOutput("deg_latency_valid", 32'(b_out_valid), 32'd0);
        tick();
        checkOutput("deg_beat_valid", 32'(b_out_valid), 32'd1);
        checkOutput("deg_beat_data",  32'(b_out_data),  32'hBEEF);
        checkOutput("deg_beat_index", 32'(b_out_index), 32'd0);
        checkOutput("deg_beat_last",  32'(b_out_last),  32'd1);
        checkOutput("deg_in_ready",   32'(b_in_ready),  32'd1);
        // accept and release in the same cycle with one slot occupied
        b_in_valid = 1'b1;
        b_in_data  = 16'h1234;
        tick();
        b_in_valid = 1'b0;
        checkOutput("deg_swap_valid",    32'(b_out_valid), 32'd0);
        checkOutput("deg_swap_busy",     32'(b_busy),      32'd1);
        checkOutput("deg_swap_in_ready", 32'(b_in_ready),  32'd1);
        checkOutput("deg_swap_overflow", 32'(b_overflow),  32'd0);
        tick();
        checkOutput("deg_second_valid", 32'(b_out_valid), 32'd1);
        checkOutput("deg_second_data",  32'(b_out_data),  32'h1234);
        checkOutput("deg_second_last",  32'(b_out_last),  32'd1);
        tick();
        checkOutput("deg_idle_valid", 32'(b_out_valid), 32'd0);
        checkOutput("deg_idle_busy",  32'(b_busy),      32'd0);
        // two buffered single-element vectors leave back-to-back
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1;
        b_in_data   = 16'h00AA;
        tick();
        b_in_data = 16'h00BB;
        tick();
        b_in_valid = 1'b0;
        checkOutput("deg_full_in_ready", 32'(b_in_ready), 32'd0);
        checkOutput("deg_full_data",     32'(b_out_data), 32'h00AA);
        b_out_ready = 1'b1;
        tick();
        checkOutput("deg_b2b_valid", 32'(b_out_valid), 32'd1);
        checkOutput("deg_b2b_data",  32'(b_out_data),  32'h00BB);
        checkOutput("deg_b2b_index", 32'(b_out_index), 32'd0);
        checkOutput("deg_b2b_last",  32'(b_out_last),  32'd1);
        tick();
        checkOutput("deg_b2b_end_valid", 32'(b_out_valid), 32'd0);
        checkOutput("deg_b2b_end_busy",  32'(b_busy),      32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
